demux1x4_behav: RTL and testbench

Byte-serial to 4-lane deserializer: the receive-side counterpart of the 4:1 lane mux in the PCIe physical-layer datapath. It takes one 8-bit byte per clock, tagged with a valid bit, and distributes consecutive time slots to lanes 0..3. Each complete group of four slots is presented as a parallel 4-lane word with per-lane valid bits and a one-cycle strobe. It sits after the serial byte stream and feeds the per-lane receive logic.

---
 rtl/demux1x4_behav.sv | 101 ++++++++++
 tb/tb_demux1x4_behav.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1x4_behav.sv
// demux1x4_behav
// Byte-serial to 4-lane deserializer. Consecutive time slots of a byte
// stream are distributed to lanes 0..3. Each completed group of four slots
// is presented as a parallel word with per-lane valid bits and a one-cycle
// strobe. Lanes 0..2 are staged; lane 3 is taken straight from the input on
// the completing edge.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high; clears all state
//   in_data    serial byte for the current slot
//   in_valid   current slot carries a valid byte
//   in_align   current slot is lane 0; realigns the slot counter
//   out0..out3 lane bytes of the last completed group (0 when lane invalid)
//   valid      per-lane valid of the last completed group (bit k = lane k)
//   out_strobe one-cycle pulse when a new group is loaded
//   frame_cnt  number of groups emitted, modulo 256
module demux1x4_behav #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_align,
  output logic [WIDTH-1:0] out0,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [3:0]       valid,
  output logic             out_strobe,
  output logic [7:0]       frame_cnt
);

  logic [1:0]       slot;
  logic [WIDTH-1:0] stage_d0, stage_d1, stage_d2;
  logic             stage_v0, stage_v1, stage_v2;
  logic             complete;

  // Realignment takes priority over completion at slot 3.
  assign complete = !in_align && (slot == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot       <= '0;
      stage_d0   <= '0;
      stage_d1   <= '0;
      stage_d2   <= '0;
      stage_v0   <= 1'b0;
      stage_v1   <= 1'b0;
      stage_v2   <= 1'b0;
      out0       <= '0;
      out1       <= '0;
      out2       <= '0;
      out3       <= '0;
      valid      <= '0;
      out_strobe <= 1'b0;
      frame_cnt  <= '0;
    end else begin
      // Staging capture and slot advance.
      if (in_align) begin
        stage_d0 <= in_data;
        stage_v0 <= in_valid;
        stage_v1 <= 1'b0;
        stage_v2 <= 1'b0;
        slot     <= 2'd1;
      end else begin
        case (slot)
          2'd0: begin
            stage_d0 <= in_data;
            stage_v0 <= in_valid;
          end
          2'd1: begin
            stage_d1 <= in_data;
            stage_v1 <= in_valid;
          end
          2'd2: begin
            stage_d2 <= in_data;
            stage_v2 <= in_valid;
          end
          default: ; // lane 3 goes directly to the output
        endcase
        slot <= slot + 2'd1;
      end

      // Group output; invalid lanes are forced to zero.
      if (complete) begin
        out0       <= stage_v0 ? stage_d0 : '0;
        out1       <= stage_v1 ? stage_d1 : '0;
        out2       <= stage_v2 ? stage_d2 : '0;
        out3       <= in_valid ? in_data  : '0;
        valid      <= {in_valid, stage_v2, stage_v1, stage_v0};
        out_strobe <= 1'b1;
        frame_cnt  <= frame_cnt + 8'd1;
      end else begin
        out_strobe <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_demux1x4_behav.sv
module tb_demux1x4_behav;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic       in_align = 1'b0;
  logic [7:0] out0, out1, out2, out3;
  logic [3:0] valid;
  logic       out_strobe;
  logic [7:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  // Reference model: group of four slots as arrays plus a position index.
  logic [7:0] g_data [4];
  logic       g_v    [4];
  logic [7:0] m_out  [4];
  logic       m_valid[4];
  logic       m_strobe;
  int         m_cnt;
  int         pos;

  demux1x4_behav #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_align(in_align), .out0(out0), .out1(out1), .out2(out2), .out3(out3),
    .valid(valid), .out_strobe(out_strobe), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      g_data[k] = '0; g_v[k] = 1'b0; m_out[k] = '0; m_valid[k] = 1'b0;
    end
    m_strobe = 1'b0;
    m_cnt = 0;
    pos = 0;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic v, input logic a);
    m_strobe = 1'b0;
    if (a) begin
      for (int k = 0; k < 4; k++) g_v[k] = 1'b0;
      pos = 0;
    end
    g_data[pos] = d;
    g_v[pos] = v;
    if (pos == 3) begin
      for (int k = 0; k < 4; k++) begin
        m_out[k] = g_v[k] ? g_data[k] : 8'h00;
        m_valid[k] = g_v[k];
      end
      m_strobe = 1'b1;
      m_cnt = (m_cnt + 1) % 256;
      pos = 0;
    end else begin
      pos = pos + 1;
    end
  endtask

  // Apply one slot, wait for its edge, then advance the model; returns #1 after the edge.
  task automatic drive(input logic [7:0] d, input logic v, input logic a);
    in_data = d; in_valid = v; in_align = a;
    @(posedge clk);
    #1;
    model_edge(d, v, a);
  endtask

  // Called #1 after an edge; the pulse ends well before the next edge.
  task automatic do_reset();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    in_data = 8'h00; in_valid = 1'b0; in_align = 1'b0;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
    checks++;
    if ({out3, out2, out1, out0, valid, out_strobe, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_initial got out=%h%h%h%h valid=%b strobe=%b cnt=%0d exp all 0",
               out3, out2, out1, out0, valid, out_strobe, frame_cnt);
    end
    // Load a group so outputs are non-zero, then reset in mid-group between edges.
    drive(8'h5A, 1, 0); drive(8'h6B, 1, 0); drive(8'h7C, 1, 0); drive(8'h8D, 1, 0);
    drive(8'h99, 1, 0); drive(8'h98, 1, 0);
    reset = 1'b1;
    #2;
    checks++;
    if ({out3, out2, out1, out0, valid, out_strobe, frame_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_async got out=%h%h%h%h valid=%b strobe=%b cnt=%0d exp all 0",
               out3, out2, out1, out0, valid, out_strobe, frame_cnt);
    end
    reset = 1'b0;
    model_reset();
    // First edge after release is slot 0: a group completes after 4 edges.
    drive(8'hC1, 1, 0); drive(8'hC2, 1, 0); drive(8'hC3, 1, 0);
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL reset_no_early_strobe got %b exp 0", out_strobe);
    end
    drive(8'hC4, 1, 0);
    checks++;
    if ({out_strobe, out3, out2, out1, out0, frame_cnt} !== {1'b1, 32'hC4C3C2C1, 8'd1}) begin
      errors++;
      $display("FAIL reset_first_group got strobe=%b out=%h%h%h%h cnt=%0d exp 1 c4c3c2c1 1",
               out_strobe, out3, out2, out1, out0, frame_cnt);
    end
  endtask

  task automatic test_continuous();
    do_reset();
    drive(8'h11, 1, 0); drive(8'h22, 1, 0); drive(8'h33, 1, 0);
    checks++;
    if (out_strobe !== 1'b0 || out0 !== 8'h00) begin
      errors++; $display("FAIL cont_pre got strobe=%b out0=%h exp 0 00", out_strobe, out0);
    end
    drive(8'h44, 1, 0);
    checks++;
    if ({out3, out2, out1, out0} !== 32'h44332211 || valid !== 4'b1111) begin
      errors++;
      $display("FAIL cont_group got out=%h%h%h%h valid=%b exp 44332211 1111",
               out3, out2, out1, out0, valid);
    end
    checks++;
    if (out_strobe !== 1'b1 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL cont_strobe got strobe=%b cnt=%0d exp 1 1", out_strobe, frame_cnt);
    end
    drive(8'h55, 1, 0);
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL cont_strobe_width got %b exp 0", out_strobe);
    end
  endtask

  task automatic test_invalid();
    drive(8'h66, 1, 0); drive(8'h77, 1, 0); drive(8'h88, 1, 0); // finish group in progress
    drive(8'hA1, 1, 0); drive(8'hB2, 0, 0); drive(8'hC3, 1, 0); drive(8'hD4, 0, 0);
    checks++;
    if ({out3, out2, out1, out0} !== 32'h00C300A1 || valid !== 4'b0101) begin
      errors++;
      $display("FAIL invalid_lanes got out=%h%h%h%h valid=%b exp 00c300a1 0101",
               out3, out2, out1, out0, valid);
    end
  endtask

  task automatic test_hold();
    logic [31:0] held;
    logic [3:0]  heldv;
    drive(8'hE1, 1, 0); drive(8'hE2, 1, 0); drive(8'hE3, 1, 0); drive(8'hE4, 1, 0);
    held = {out3, out2, out1, out0};
    heldv = valid;
    for (int i = 0; i < 3; i++) begin
      drive(8'h30 + 8'(i), 0, 0);
      checks++;
      if ({out3, out2, out1, out0} !== 32'hE4E3E2E1 || heldv !== 4'b1111 ||
          valid !== 4'b1111 || out_strobe !== 1'b0) begin
        errors++;
        $display("FAIL hold_%0d got out=%h valid=%b strobe=%b exp e4e3e2e1 1111 0",
                 i, {out3, out2, out1, out0}, valid, out_strobe);
      end
    end
    drive(8'h9F, 1, 0);
    checks++;
    if (out_strobe !== 1'b1 || {out3, out2, out1, out0} !== 32'h9F000000 || valid !== 4'b1000) begin
      errors++;
      $display("FAIL hold_release got strobe=%b out=%h valid=%b exp 1 9f000000 1000 (prev %h)",
               out_strobe, {out3, out2, out1, out0}, valid, held);
    end
  endtask

  task automatic test_realign();
    int strobes;
    do_reset();
    strobes = 0;
    drive(8'h01, 1, 0); strobes += int'(out_strobe);
    drive(8'h02, 1, 0); strobes += int'(out_strobe);
    drive(8'h10, 1, 1); strobes += int'(out_strobe);
    drive(8'h20, 1, 0); strobes += int'(out_strobe);
    drive(8'h30, 1, 0); strobes += int'(out_strobe);
    drive(8'h40, 1, 0); strobes += int'(out_strobe);
    checks++;
    if (strobes != 1 || {out3, out2, out1, out0} !== 32'h40302010 || frame_cnt !== 8'd1) begin
      errors++;
      $display("FAIL realign_mid got strobes=%0d out=%h cnt=%0d exp 1 40302010 1",
               strobes, {out3, out2, out1, out0}, frame_cnt);
    end
    // Realign on slot 3: no completion, byte becomes lane 0, lanes 1..2 emptied.
    drive(8'hA0, 1, 0); drive(8'hA1, 1, 0); drive(8'hA2, 1, 0);
    drive(8'hB0, 1, 1);
    checks++;
    if (out_strobe !== 1'b0 || frame_cnt !== 8'd1) begin
      errors++; $display("FAIL realign_slot3 got strobe=%b cnt=%0d exp 0 1", out_strobe, frame_cnt);
    end
    drive(8'hB1, 0, 0); drive(8'hB2, 1, 0);
    checks++;
    if (out_strobe !== 1'b0) begin
      errors++; $display("FAIL realign_slot3_early got strobe=%b exp 0", out_strobe);
    end
    drive(8'hB3, 1, 0);
    checks++;
    if (out_strobe !== 1'b1 || {out3, out2, out1, out0} !== 32'hB3B200B0 || valid !== 4'b1101) begin
      errors++;
      $display("FAIL realign_slot3_group got strobe=%b out=%h valid=%b exp 1 b3b200b0 1101",
               out_strobe, {out3, out2, out1, out0}, valid);
    end
    // Emptied lanes stay zero unless rewritten: realign then complete with lanes 1..2 skipped via invalid.
    drive(8'hC0, 1, 1); drive(8'hC1, 0, 0); drive(8'hC2, 0, 0); drive(8'hC3, 0, 0);
    checks++;
    if ({out3, out2, out1, out0} !== 32'h000000C0 || valid !== 4'b0001) begin
      errors++;
      $display("FAIL realign_empty got out=%h valid=%b exp 000000c0 0001",
               {out3, out2, out1, out0}, valid);
    end
  endtask

  task automatic test_wrap();
    int strobes;
    do_reset();
    strobes = 0;
    for (int g = 1; g <= 256; g++) begin
      for (int s = 0; s < 4; s++) begin
        drive(8'($urandom), 1, 0);
        strobes += int'(out_strobe);
      end
      if (g == 255) begin
        checks++;
        if (frame_cnt !== 8'd255) begin
          errors++; $display("FAIL wrap_255 got %0d exp 255", frame_cnt);
        end
      end
    end
    checks++;
    if (frame_cnt !== 8'd0 || strobes != 256) begin
      errors++; $display("FAIL wrap_256 got cnt=%0d strobes=%0d exp 0 256", frame_cnt, strobes);
    end
  endtask

  task automatic test_random();
    logic [7:0] d;
    logic v, a;
    int bad;
    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      d = 8'($urandom);
      v = ($urandom_range(0, 3) != 0);
      a = ($urandom_range(0, 9) == 0);
      drive(d, v, a);
      checks++;
      if ({out3, out2, out1, out0} !== {m_out[3], m_out[2], m_out[1], m_out[0]} ||
          valid !== {m_valid[3], m_valid[2], m_valid[1], m_valid[0]} ||
          out_strobe !== m_strobe || frame_cnt !== 8'(m_cnt)) begin
        errors++;
        if (bad < 10)
          $display("FAIL random_%0d got out=%h valid=%b strobe=%b cnt=%0d exp out=%h valid=%b strobe=%b cnt=%0d",
                   i, {out3, out2, out1, out0}, valid, out_strobe, frame_cnt,
                   {m_out[3], m_out[2], m_out[1], m_out[0]},
                   {m_valid[3], m_valid[2], m_valid[1], m_valid[0]}, m_strobe, m_cnt);
        bad++;
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_continuous();
    test_invalid();
    test_hold();
    test_realign();
    test_wrap();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
